// File: rtl/ika9958_st_vint.sv
// ============================================================================
// Module   : ika9958_st_vint
// Brief    : V9958 vertical line counter, blanking/sync and F/FH interrupt flags.
//            Optional interlace (odd/even field) via IKA9958_ST_VINT_INTERLACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ika9958_st_vint #(
  parameter int VSYNC_LINES = 3
) (
  input  logic       phiA,
  input  logic       RST_async_n,
  input  logic       phiL_NCEN,
  input  logic       i_LINE_END,
  input  logic       i_HINT_POS,
  input  logic       i_PAL,
  input  logic       i_LN,
  input  logic [7:0] i_LINE_CMP,
  input  logic       i_IE0,
  input  logic       i_IE1,
  input  logic       i_S0_RD,
  input  logic       i_S1_RD,
  output logic [8:0] o_VCNTR,
  output logic       o_VBLANK,
  output logic       o_VSYNC,
  output logic       o_F,
  output logic       o_FH,
  output logic       o_INT_n,
  output logic       o_EO
);

  localparam logic [8:0] c_vs_len = 9'(VSYNC_LINES);

  logic [8:0] r_vcntr;
  logic       r_pal;
  logic       r_ln;
  logic       r_f;
  logic       r_fh;

  logic [8:0] w_total;
  logic [8:0] w_active;
  logic [8:0] w_vs;
  logic       w_last;
  logic       w_f_set;
  logic       w_fh_set;

`ifdef IKA9958_ST_VINT_INTERLACE_EN
  logic r_eo;

  // The odd field carries one extra line so the two fields interleave.
  assign w_total = (r_pal ? 9'd313 : 9'd262) + {8'd0, r_eo};
  assign o_EO    = r_eo;

  always_ff @(posedge phiA or negedge RST_async_n) begin
    if (!RST_async_n) begin
      r_eo <= 1'b0;
    end else if (phiL_NCEN && i_LINE_END && w_last) begin
      r_eo <= ~r_eo;
    end
  end
`else
  assign w_total = r_pal ? 9'd313 : 9'd262;
  assign o_EO    = 1'b0;
`endif

  assign w_active = r_ln  ? 9'd212 : 9'd192;
  assign w_vs     = r_pal ? 9'd259 : 9'd234;
  assign w_last   = (r_vcntr == w_total - 9'd1);

  // Both flag conditions look at the pre-increment line number.
  assign w_f_set  = i_LINE_END && (r_vcntr == w_active - 9'd1);
  assign w_fh_set = i_HINT_POS && (r_vcntr[7:0] == i_LINE_CMP) && (r_vcntr < w_active);

  always_ff @(posedge phiA or negedge RST_async_n) begin
    if (!RST_async_n) begin
      r_vcntr <= 9'd0;
      r_pal   <= 1'b0;
      r_ln    <= 1'b0;
      r_f     <= 1'b0;
      r_fh    <= 1'b0;
    end else if (phiL_NCEN) begin
      if (i_LINE_END) begin
        if (w_last) begin
          r_vcntr <= 9'd0;
          r_pal   <= i_PAL;
          r_ln    <= i_LN;
        end else begin
          r_vcntr <= r_vcntr + 9'd1;
        end
      end

      if (w_f_set) begin
        r_f <= 1'b1;
      end else if (i_S0_RD) begin
        r_f <= 1'b0;
      end

      if (w_fh_set) begin
        r_fh <= 1'b1;
      end else if (i_S1_RD) begin
        r_fh <= 1'b0;
      end
    end
  end

  assign o_VCNTR  = r_vcntr;
  assign o_VBLANK = (r_vcntr >= w_active);
  assign o_VSYNC  = (r_vcntr >= w_vs) && (r_vcntr < w_vs + c_vs_len);
  assign o_F      = r_f;
  assign o_FH     = r_fh;
  assign o_INT_n  = ~((r_f & i_IE0) | (r_fh & i_IE1));

endmodule

`default_nettype wire

// File: tb/tb_ika9958_st_vint.sv
// ============================================================================
// Module   : tb_ika9958_st_vint
// Brief    : Self-checking bench for ika9958_st_vint (directed vector table
//            plus frame-length, flag-coincidence and reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ika9958_st_vint;

  logic       phiA = 1'b0;
  logic       RST_async_n;
  logic       phiL_NCEN;
  logic       i_LINE_END, i_HINT_POS, i_PAL, i_LN;
  logic [7:0] i_LINE_CMP;
  logic       i_IE0, i_IE1, i_S0_RD, i_S1_RD;
  logic [8:0] o_VCNTR;
  logic       o_VBLANK, o_VSYNC, o_F, o_FH, o_INT_n, o_EO;

  int errors = 0;
  int checks = 0;
  int exp_eo = 0;

  ika9958_st_vint #(.VSYNC_LINES(3)) dut (
    .phiA(phiA), .RST_async_n(RST_async_n), .phiL_NCEN(phiL_NCEN),
    .i_LINE_END(i_LINE_END), .i_HINT_POS(i_HINT_POS), .i_PAL(i_PAL), .i_LN(i_LN),
    .i_LINE_CMP(i_LINE_CMP), .i_IE0(i_IE0), .i_IE1(i_IE1),
    .i_S0_RD(i_S0_RD), .i_S1_RD(i_S1_RD),
    .o_VCNTR(o_VCNTR), .o_VBLANK(o_VBLANK), .o_VSYNC(o_VSYNC),
    .o_F(o_F), .o_FH(o_FH), .o_INT_n(o_INT_n), .o_EO(o_EO)
  );

  always #5 phiA = ~phiA;

  typedef struct {
    int         pre;
    logic [7:0] cmp;
    logic       le, hp, s0, s1, en;
    int         v;
    logic       f, fh, intn;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs applied before the edge, sampled 1 time unit after it.
  task automatic cyc(input logic le, input logic hp, input logic s0, input logic s1, input logic en);
    i_LINE_END = le; i_HINT_POS = hp; i_S0_RD = s0; i_S1_RD = s1; phiL_NCEN = en;
    @(posedge phiA); #1;
    i_LINE_END = 0; i_HINT_POS = 0; i_S0_RD = 0; i_S1_RD = 0; phiL_NCEN = 1;
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vcntr"}, o_VCNTR, 0);
    chk({tag, "_f"}, o_F, 0);
    chk({tag, "_fh"}, o_FH, 0);
    chk({tag, "_eo"}, o_EO, 0);
    chk({tag, "_vblank"}, o_VBLANK, 0);
    chk({tag, "_vsync"}, o_VSYNC, 0);
    chk({tag, "_int_n"}, o_INT_n, 1);
  endtask

  // Asserts reset a few units after an edge; outputs are checked before the next edge.
  task automatic pulse_reset(input string tag);
    #2 RST_async_n = 0;
    #1 chk_reset_vals(tag);
    @(posedge phiA); #1;
    RST_async_n = 1;
  endtask

  task automatic run_frame(input int total, input int active, input int vs, input bit chg);
    for (int n = 0; n < total; n++) begin
      chk($sformatf("line%0d_vcntr", n), o_VCNTR, n);
      chk($sformatf("line%0d_vblank", n), o_VBLANK, (n >= active));
      chk($sformatf("line%0d_vsync", n), o_VSYNC, (n >= vs && n < vs + 3));
      if (chg && n == 50) begin
        i_PAL = 1;
        i_LN  = 1;
      end
      cyc(1, 0, 0, 0, 1);
    end
    chk($sformatf("wrap%0d_vcntr", total), o_VCNTR, 0);
`ifdef IKA9958_ST_VINT_INTERLACE_EN
    exp_eo ^= 1;
`endif
    chk($sformatf("wrap%0d_eo", total), o_EO, exp_eo);
  endtask

  initial begin
    //            pre cmp     le hp s0 s1 en   v    f  fh intn
    tbl[0]  = '{99, 8'd100, 0, 1, 0, 0, 1,  99, 0, 0, 1};
    tbl[1]  = '{0,  8'd100, 1, 1, 0, 0, 1, 100, 0, 0, 1};
    tbl[2]  = '{0,  8'd100, 0, 1, 0, 0, 0, 100, 0, 0, 1};
    tbl[3]  = '{0,  8'd100, 0, 1, 0, 0, 1, 100, 0, 1, 0};
    tbl[4]  = '{0,  8'd100, 0, 0, 0, 1, 1, 100, 0, 0, 1};
    tbl[5]  = '{0,  8'd100, 0, 1, 0, 1, 1, 100, 0, 1, 0};
    tbl[6]  = '{0,  8'd100, 0, 0, 0, 1, 1, 100, 0, 0, 1};
    tbl[7]  = '{0,  8'd100, 1, 1, 0, 0, 1, 101, 0, 1, 0};
    tbl[8]  = '{0,  8'd100, 0, 0, 0, 1, 1, 101, 0, 0, 1};
    tbl[9]  = '{0,  8'd100, 1, 0, 0, 0, 0, 101, 0, 0, 1};
    tbl[10] = '{90, 8'd100, 1, 0, 0, 0, 1, 192, 1, 0, 0};
    tbl[11] = '{0,  8'd100, 0, 0, 1, 0, 1, 192, 0, 0, 1};
    tbl[12] = '{8,  8'd200, 0, 1, 0, 0, 1, 200, 0, 0, 1};

    RST_async_n = 0; phiL_NCEN = 1;
    i_LINE_END = 0; i_HINT_POS = 0; i_PAL = 0; i_LN = 0;
    i_LINE_CMP = 8'd100; i_IE0 = 1; i_IE1 = 1; i_S0_RD = 0; i_S1_RD = 0;
    #3 chk_reset_vals("por");
    @(posedge phiA); #1;
    RST_async_n = 1;

    for (int i = 0; i < 13; i++) begin
      i_LINE_CMP = tbl[i].cmp;
      adv(tbl[i].pre);
      cyc(tbl[i].le, tbl[i].hp, tbl[i].s0, tbl[i].s1, tbl[i].en);
      chk($sformatf("vec%0d_vcntr", i), o_VCNTR, tbl[i].v);
      chk($sformatf("vec%0d_f", i), o_F, tbl[i].f);
      chk($sformatf("vec%0d_fh", i), o_FH, tbl[i].fh);
      chk($sformatf("vec%0d_int_n", i), o_INT_n, tbl[i].intn);
    end

    // Wrap, then S#0 read coincident with the F set: set must win.
    adv(62);
    chk("c_wrap_vcntr", o_VCNTR, 0);
`ifdef IKA9958_ST_VINT_INTERLACE_EN
    chk("c_wrap_eo", o_EO, 1);
`else
    chk("c_wrap_eo", o_EO, 0);
`endif
    adv(191);
    cyc(1, 0, 1, 0, 1);
    chk("c_coinc_vcntr", o_VCNTR, 192);
    chk("c_coinc_f", o_F, 1);
    chk("c_coinc_int_n", o_INT_n, 0);
    i_IE0 = 0;
    #1 chk("c_ie0_mask_int_n", o_INT_n, 1);
    cyc(0, 0, 1, 0, 1);
    chk("c_s0_clear_f", o_F, 0);
    i_IE0 = 1;

    // Reset mid-frame from blanking, then restart and reset again at line 120.
    cyc(0, 0, 0, 0, 1);
    adv(1);
    pulse_reset("rst_blank");
    chk("rst_rel_vcntr", o_VCNTR, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_idle_vcntr", o_VCNTR, 0);
    adv(1);
    chk("rst_first_le_vcntr", o_VCNTR, 1);
    adv(119);
    i_LINE_CMP = 8'd120;
    cyc(0, 1, 0, 0, 1);
    chk("l120_fh", o_FH, 1);
    chk("l120_int_n", o_INT_n, 0);
    pulse_reset("rst_l120");
    exp_eo = 0;

    // Frame lengths, blanking and sync; mode change at line 50 takes effect next frame.
    run_frame(262, 192, 234, 0);
    run_frame(262 + exp_eo, 192, 234, 1);
    run_frame(313 + exp_eo, 212, 259, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
